shift_unit_seq: RTL and testbench

Parametrised multi-mode sequential shift register. It is the successor to the fixed 32-bit right-shift/parallel-load register used in the divider datapath. It supports parallel load, four shift modes, and a shift amount executed one bit per clock under a start/busy/done handshake. It serves the divider, the multiplier and the future barrel-less shift instructions of the ALU.

---
 rtl/shift_unit_seq.sv | 139 +++++++++++++
 tb/tb_shift_unit_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-mode sequential shift register with parallel load.
//
// An operation is started with a start/amt request. It then shifts one bit per clock for amt
// clocks under a busy/done handshake. All state updates on the falling edge of clk.
//
// Ports:
//   clk    clock; registers update on the falling edge
//   r      synchronous active-high reset (highest priority)
//   value  parallel load data
//   load   parallel load strobe; also aborts a running shift
//   start  begin a shift operation (ignored while shifting)
//   mode   00 logical right, 01 logical left, 10 arithmetic right, 11 rotate right
//   amt    number of single-bit shift steps
//   sin    serial fill bit for the logical modes, sampled at every step
//   Q      register contents
//   sout   bit shifted out by the most recent shift step
//   busy   high while shifting
//   done   one-cycle completion pulse
module shift_unit_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 5
) (
  input  logic             clk,
  input  logic             r,
  input  logic [WIDTH-1:0] value,
  input  logic             load,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic             sin,
  output logic [WIDTH-1:0] Q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic [1:0]       mode_q, mode_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;

  // One shift step of the current contents using the latched mode.
  logic [WIDTH-1:0] step_q;
  logic             step_sout;

  always_comb begin
    step_q    = q_q;
    step_sout = 1'b0;
    unique case (mode_q)
      2'b00: begin
        step_q    = {sin, q_q[WIDTH-1:1]};
        step_sout = q_q[0];
      end
      2'b01: begin
        step_q    = {q_q[WIDTH-2:0], sin};
        step_sout = q_q[WIDTH-1];
      end
      2'b10: begin
        step_q    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        step_sout = q_q[0];
      end
      2'b11: begin
        step_q    = {q_q[0], q_q[WIDTH-1:1]};
        step_sout = q_q[0];
      end
      default: begin
        step_q    = q_q;
        step_sout = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    sout_d  = sout_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (load) begin
          q_d     = value;
          sout_d  = 1'b0;
          state_d = StIdle;
        end else if (start) begin
          if (amt != '0) begin
            mode_d  = mode;
            cnt_d   = amt;
            state_d = StShift;
          end else begin
            // Zero-length operation still reports completion.
            state_d = StDone;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        if (load) begin
          // Abort: no done pulse for an interrupted operation.
          q_d     = value;
          sout_d  = 1'b0;
          state_d = StIdle;
        end else begin
          q_d     = step_q;
          sout_d  = step_sout;
          cnt_d   = cnt_q - AMT_W'(1);
          state_d = (cnt_q == AMT_W'(1)) ? StDone : StShift;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(negedge clk) begin
    if (r) begin
      state_q <= StIdle;
      q_q     <= '0;
      sout_q  <= 1'b0;
      mode_q  <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Q    = q_q;
  assign sout = sout_q;
  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_shift_unit_seq.sv
module tb_shift_unit_seq;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        a_r, a_load, a_start, a_sin;
  logic [31:0] a_value;
  logic [1:0]  a_mode;
  logic [4:0]  a_amt;
  logic [31:0] a_q;
  logic        a_sout, a_busy, a_done;

  // 8-bit instance for abort/reset checks
  logic        b_r, b_load, b_start, b_sin;
  logic [7:0]  b_value;
  logic [1:0]  b_mode;
  logic [2:0]  b_amt;
  logic [7:0]  b_q;
  logic        b_sout, b_busy, b_done;

  shift_unit_seq #(.WIDTH(32), .AMT_W(5)) u_dut_a (
    .clk(clk), .r(a_r), .value(a_value), .load(a_load), .start(a_start), .mode(a_mode),
    .amt(a_amt), .sin(a_sin), .Q(a_q), .sout(a_sout), .busy(a_busy), .done(a_done)
  );

  shift_unit_seq #(.WIDTH(8), .AMT_W(3)) u_dut_b (
    .clk(clk), .r(b_r), .value(b_value), .load(b_load), .start(b_start), .mode(b_mode),
    .amt(b_amt), .sin(b_sin), .Q(b_q), .sout(b_sout), .busy(b_busy), .done(b_done)
  );

  typedef struct {
    logic [31:0] q;
    logic        sout;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse of the 32-bit instance is matched against the scoreboard.
  always @(posedge clk) begin
    if (a_done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_done: got done=1 expected no pending operation");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_q"}, a_q, e.q);
        check({e.name, "_sout"}, {31'd0, a_sout}, {31'd0, e.sout});
      end
    end
    if (b_done === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL b_unexpected_done: got done=1 expected 0");
    end
  end

  // Caller is at a posedge; returns at the posedge after the load edge.
  task automatic a_do_load(input logic [31:0] v, input string nm);
    a_load  = 1'b1;
    a_value = v;
    @(posedge clk);
    a_load = 1'b0;
    check(nm, a_q, v);
  endtask

  // Issues start at the current posedge; returns at the posedge where done is visible,
  // or one posedge later when chk_idle is set.
  task automatic a_run_shift(input logic [1:0] m, input logic [4:0] amt, input logic s,
                             input logic [31:0] eq, input logic es, input string nm,
                             input bit chk_idle);
    int  nbusy;
    bit  seen;
    exp_t e;
    e.q = eq; e.sout = es; e.name = nm;
    sb.push_back(e);
    a_start = 1'b1;
    a_mode  = m;
    a_amt   = amt;
    a_sin   = s;
    @(posedge clk);
    a_start = 1'b0;
    // Scramble mode/amt: the operation must use the latched copies.
    a_mode  = ~m;
    a_amt   = ~amt;
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (a_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (a_busy === 1'b1) nbusy++;
      @(posedge clk);
    end
    check({nm, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({nm, "_busy_cycles"}, nbusy, {27'd0, amt});
    if (chk_idle) begin
      @(posedge clk);
      check({nm, "_done_1cyc"}, {31'd0, a_done}, 32'd0);
      check({nm, "_idle_busy"}, {31'd0, a_busy}, 32'd0);
    end
  endtask

  initial begin
    a_r = 1'b1; a_load = 1'b1; a_value = 32'hFFFF_FFFF; a_start = 1'b0;
    a_mode = 2'b00; a_amt = 5'd0; a_sin = 1'b0;
    b_r = 1'b1; b_load = 1'b1; b_value = 8'hFF; b_start = 1'b0;
    b_mode = 2'b00; b_amt = 3'd0; b_sin = 1'b0;

    // Reset held for two falling edges with load asserted.
    @(posedge clk);
    @(posedge clk);
    check("rst_q", a_q, 32'h0);
    check("rst_sout", {31'd0, a_sout}, 32'd0);
    check("rst_busy", {31'd0, a_busy}, 32'd0);
    check("rst_done", {31'd0, a_done}, 32'd0);
    check("b_rst_q", {24'd0, b_q}, 32'h0);
    a_r = 1'b0; a_load = 1'b0;
    b_r = 1'b0; b_load = 1'b0;

    // Arithmetic right.
    a_do_load(32'h8000_0001, "ld1");
    a_run_shift(2'b10, 5'd4, 1'b0, 32'hF800_0000, 1'b0, "asr4", 1'b1);

    // Rotate, then back-to-back logical right from DONE.
    a_do_load(32'h0000_000F, "ld2");
    a_run_shift(2'b11, 5'd4, 1'b0, 32'hF000_0000, 1'b1, "ror4", 1'b0);
    a_run_shift(2'b00, 5'd28, 1'b0, 32'h0000_000F, 1'b0, "lsr28", 1'b1);

    // Long logical left, then logical right filling with ones.
    a_do_load(32'h0000_0001, "ld3");
    a_run_shift(2'b01, 5'd31, 1'b0, 32'h8000_0000, 1'b0, "lsl31", 1'b1);
    a_run_shift(2'b00, 5'd3, 1'b1, 32'hF000_0000, 1'b0, "lsr3_sin1", 1'b1);

    // Zero-length operation: done without busy, Q/sout unchanged.
    a_run_shift(2'b01, 5'd0, 1'b1, 32'hF000_0000, 1'b0, "amt0", 1'b1);

    // Load and start on the same edge: load wins, nothing starts.
    a_load = 1'b1; a_value = 32'h1234_5678;
    a_start = 1'b1; a_mode = 2'b01; a_amt = 5'd5;
    @(posedge clk);
    a_load = 1'b0; a_start = 1'b0;
    check("ldst_q", a_q, 32'h1234_5678);
    check("ldst_busy", {31'd0, a_busy}, 32'd0);
    @(posedge clk);
    check("ldst_busy2", {31'd0, a_busy}, 32'd0);
    check("ldst_done2", {31'd0, a_done}, 32'd0);

    // Logical left filling with ones.
    a_run_shift(2'b01, 5'd8, 1'b1, 32'h3456_78FF, 1'b0, "lsl8_sin1", 1'b1);

    // 8-bit instance: abort by load after two shifts.
    b_load = 1'b1; b_value = 8'hFF;
    @(posedge clk);
    b_load = 1'b0;
    check("b_ld", {24'd0, b_q}, 32'hFF);
    b_start = 1'b1; b_mode = 2'b00; b_amt = 3'd7; b_sin = 1'b0;
    @(posedge clk);
    b_start = 1'b0;
    check("b_busy", {31'd0, b_busy}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    check("b_2shift_q", {24'd0, b_q}, 32'h3F);
    b_load = 1'b1; b_value = 8'h5A;
    @(posedge clk);
    b_load = 1'b0;
    check("b_abort_q", {24'd0, b_q}, 32'h5A);
    check("b_abort_sout", {31'd0, b_sout}, 32'd0);
    check("b_abort_busy", {31'd0, b_busy}, 32'd0);
    repeat (8) @(posedge clk);
    check("b_abort_idle", {31'd0, b_busy}, 32'd0);

    // 8-bit instance: reset after three shifts.
    b_load = 1'b1; b_value = 8'hFF;
    @(posedge clk);
    b_load = 1'b0;
    b_start = 1'b1;
    @(posedge clk);
    b_start = 1'b0;
    repeat (3) @(posedge clk);
    check("b_3shift_q", {24'd0, b_q}, 32'h1F);
    check("b_3shift_sout", {31'd0, b_sout}, 32'd1);
    b_r = 1'b1;
    @(posedge clk);
    b_r = 1'b0;
    check("b_rst_mid_q", {24'd0, b_q}, 32'h0);
    check("b_rst_mid_sout", {31'd0, b_sout}, 32'd0);
    check("b_rst_mid_busy", {31'd0, b_busy}, 32'd0);
    check("b_rst_mid_done", {31'd0, b_done}, 32'd0);
    repeat (8) @(posedge clk);
    check("b_rst_idle", {31'd0, b_busy}, 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
